// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//
// Shares one single-ported data memory between the CPU load/store unit (m0)
// and the DMA/debug port (m1). One access is granted per cycle. The grant and
// the memory-side bus are combinational from the requests. Read responses come
// back one cycle later and are routed to the master that issued the read.
//
// Build option:
//   DMEM_ARB_RR_EN  defined   -> round-robin arbitration between m0 and m1
//                   undefined -> fixed priority m0 > m1, with a starvation
//                                guard that force-grants m1 after STARVE_LIMIT
//                                consecutive denied cycles
//
// Parameters:
//   ADDR_W        address width
//   DATA_W        data width (strobe width is DATA_W/8)
//   STARVE_LIMIT  denied cycles before m1 is force-granted (1..15)
//
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   mK_req/we/addr/wdata/strb      request from master K (K = 0, 1)
//   mK_gnt                         access accepted this cycle
//   mK_rvalid/rdata                read response for master K
//   mem_addr/write_data/write_en/
//   write_strb/read_en             memory command bus (all 0 when idle)
//   mem_read_data                  memory read data, 1 cycle after read_en
//   arb_owner                      granted master; holds last value when idle
// -----------------------------------------------------------------------------
module dmem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  m0_req,
  input  logic                  m0_we,
  input  logic [ADDR_W-1:0]     m0_addr,
  input  logic [DATA_W-1:0]     m0_wdata,
  input  logic [DATA_W/8-1:0]   m0_strb,
  output logic                  m0_gnt,
  output logic                  m0_rvalid,
  output logic [DATA_W-1:0]     m0_rdata,
  input  logic                  m1_req,
  input  logic                  m1_we,
  input  logic [ADDR_W-1:0]     m1_addr,
  input  logic [DATA_W-1:0]     m1_wdata,
  input  logic [DATA_W/8-1:0]   m1_strb,
  output logic                  m1_gnt,
  output logic                  m1_rvalid,
  output logic [DATA_W-1:0]     m1_rdata,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_write_data,
  output logic                  mem_write_en,
  output logic [DATA_W/8-1:0]   mem_write_strb,
  output logic                  mem_read_en,
  input  logic [DATA_W-1:0]     mem_read_data,
  output logic                  arb_owner
);

  localparam int STRB_W = DATA_W / 8;

  // Read pipeline and ownership state.
  logic rd_pending_q, rd_pending_d;
  logic rd_owner_q,   rd_owner_d;
  logic last_owner_q, last_owner_d;
  logic arb_owner_q,  arb_owner_d;

  // Arbitration result for the current cycle.
  logic grant_valid;
  logic grant_idx;
  logic sel_we;

`ifndef DMEM_ARB_RR_EN
  localparam logic [3:0] STARVE_LIMIT_C = STARVE_LIMIT[3:0];

  logic [3:0] starve_cnt_q, starve_cnt_d;
  logic       force_m1;

  // Fixed priority m0 > m1, overridden once m1 has waited STARVE_LIMIT cycles.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = 1'b0;
    force_m1    = m1_req && (starve_cnt_q >= STARVE_LIMIT_C);
    if (!rst_n) begin
      grant_valid = 1'b0;
      grant_idx   = 1'b0;
    end else if (force_m1) begin
      grant_valid = 1'b1;
      grant_idx   = 1'b1;
    end else if (m0_req) begin
      grant_valid = 1'b1;
      grant_idx   = 1'b0;
    end else if (m1_req) begin
      grant_valid = 1'b1;
      grant_idx   = 1'b1;
    end else begin
      grant_valid = 1'b0;
      grant_idx   = 1'b0;
    end
  end

  // Count consecutive cycles in which m1 asks and loses; saturates at 15.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (m1_req && !(grant_valid && grant_idx)) begin
      if (starve_cnt_q != 4'd15) begin
        starve_cnt_d = starve_cnt_q + 4'd1;
      end else begin
        starve_cnt_d = starve_cnt_q;
      end
    end else begin
      starve_cnt_d = 4'd0;
    end
  end

  // Starvation counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt_q <= 4'd0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end
`else
  // Round-robin: on contention, the master that did not win last time wins.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = 1'b0;
    if (!rst_n) begin
      grant_valid = 1'b0;
      grant_idx   = 1'b0;
    end else if (m0_req && m1_req) begin
      grant_valid = 1'b1;
      grant_idx   = ~last_owner_q;
    end else if (m0_req) begin
      grant_valid = 1'b1;
      grant_idx   = 1'b0;
    end else if (m1_req) begin
      grant_valid = 1'b1;
      grant_idx   = 1'b1;
    end else begin
      grant_valid = 1'b0;
      grant_idx   = 1'b0;
    end
  end
`endif

  assign m0_gnt = grant_valid & ~grant_idx;
  assign m1_gnt = grant_valid &  grant_idx;

  // Memory command bus: mux of the granted master, all zero when idle.
  always_comb begin
    mem_addr       = {ADDR_W{1'b0}};
    mem_write_data = {DATA_W{1'b0}};
    mem_write_strb = {STRB_W{1'b0}};
    mem_write_en   = 1'b0;
    mem_read_en    = 1'b0;
    sel_we         = 1'b0;
    if (grant_valid) begin
      if (grant_idx) begin
        sel_we         = m1_we;
        mem_addr       = m1_addr;
        mem_write_data = m1_wdata;
        mem_write_strb = m1_we ? m1_strb : {STRB_W{1'b0}};
      end else begin
        sel_we         = m0_we;
        mem_addr       = m0_addr;
        mem_write_data = m0_wdata;
        mem_write_strb = m0_we ? m0_strb : {STRB_W{1'b0}};
      end
      mem_write_en = sel_we;
      mem_read_en  = ~sel_we;
    end else begin
      sel_we = 1'b0;
    end
  end

  // Next-state for read tracking and ownership history.
  always_comb begin
    rd_pending_d = grant_valid & ~sel_we;
    rd_owner_d   = rd_owner_q;
    last_owner_d = last_owner_q;
    arb_owner_d  = arb_owner_q;
    if (grant_valid) begin
      last_owner_d = grant_idx;
      arb_owner_d  = grant_idx;
      if (!sel_we) begin
        rd_owner_d = grant_idx;
      end else begin
        rd_owner_d = rd_owner_q;
      end
    end else begin
      last_owner_d = last_owner_q;
      arb_owner_d  = arb_owner_q;
    end
  end

  // State registers; a pending read is dropped by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_pending_q <= 1'b0;
      rd_owner_q   <= 1'b0;
      last_owner_q <= 1'b1;
      arb_owner_q  <= 1'b0;
    end else begin
      rd_pending_q <= rd_pending_d;
      rd_owner_q   <= rd_owner_d;
      last_owner_q <= last_owner_d;
      arb_owner_q  <= arb_owner_d;
    end
  end

  // Current grant shows immediately; otherwise the last granted master.
  assign arb_owner = grant_valid ? grant_idx : arb_owner_q;

  assign m0_rvalid = rd_pending_q & ~rd_owner_q;
  assign m1_rvalid = rd_pending_q &  rd_owner_q;
  assign m0_rdata  = m0_rvalid ? mem_read_data : {DATA_W{1'b0}};
  assign m1_rdata  = m1_rvalid ? mem_read_data : {DATA_W{1'b0}};

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
//
// Self-checking bench for dmem_arbiter: a table of directed vectors, hand
// sequences for contention and reset during a read, then randomized traffic
// compared against a cycle-level reference model.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;

  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int LIMIT = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          m0_req, m0_we, m1_req, m1_we;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [DW-1:0] m0_wdata, m1_wdata;
  logic [3:0]    m0_strb, m1_strb;
  logic          m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_write_data, mem_read_data;
  logic          mem_write_en, mem_read_en, arb_owner;
  logic [3:0]    mem_write_strb;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_strb(m0_strb), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_strb(m1_strb), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .mem_addr(mem_addr), .mem_write_data(mem_write_data), .mem_write_en(mem_write_en),
    .mem_write_strb(mem_write_strb), .mem_read_en(mem_read_en),
    .mem_read_data(mem_read_data), .arb_owner(arb_owner)
  );

  typedef struct packed {
    logic          m0_gnt;
    logic          m1_gnt;
    logic          m0_rvalid;
    logic [DW-1:0] m0_rdata;
    logic          m1_rvalid;
    logic [DW-1:0] m1_rdata;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_we;
    logic [3:0]    mem_strb;
    logic          mem_re;
    logic          owner;
  } obs_t;

  typedef struct {
    logic          act;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [3:0]    strb;
  } rq_t;

  typedef struct {
    rq_t           r0;
    rq_t           r1;
    logic [DW-1:0] rd;
    obs_t          exp;
  } vec_t;

  function automatic obs_t sample();
    obs_t o;
    o.m0_gnt = m0_gnt;       o.m1_gnt = m1_gnt;
    o.m0_rvalid = m0_rvalid; o.m0_rdata = m0_rdata;
    o.m1_rvalid = m1_rvalid; o.m1_rdata = m1_rdata;
    o.mem_addr = mem_addr;   o.mem_wdata = mem_write_data;
    o.mem_we = mem_write_en; o.mem_strb = mem_write_strb;
    o.mem_re = mem_read_en;  o.owner = arb_owner;
    return o;
  endfunction

  function automatic rq_t mkrq(logic act, logic we, logic [AW-1:0] a,
                               logic [DW-1:0] d, logic [3:0] s);
    rq_t r;
    r.act = act; r.we = we; r.addr = a; r.wdata = d; r.strb = s;
    return r;
  endfunction

  // Expected bus for a grant of request r to master idx.
  function automatic obs_t grant_obs(rq_t r, logic idx);
    obs_t e = '0;
    e.m0_gnt = ~idx; e.m1_gnt = idx;
    e.mem_addr = r.addr; e.mem_wdata = r.wdata;
    e.mem_we = r.we; e.mem_re = ~r.we;
    e.mem_strb = r.we ? r.strb : 4'h0;
    e.owner = idx;
    return e;
  endfunction

  task automatic drive(rq_t a, rq_t b, logic [DW-1:0] rd);
    m0_req = a.act; m0_we = a.we; m0_addr = a.addr; m0_wdata = a.wdata; m0_strb = a.strb;
    m1_req = b.act; m1_we = b.we; m1_addr = b.addr; m1_wdata = b.wdata; m1_strb = b.strb;
    mem_read_data = rd;
  endtask

  task automatic check(input string name, input obs_t exp);
    obs_t act;
    act = sample();
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rq_t z;
    z = mkrq(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    @(negedge clk);
    drive(z, z, 32'h0);
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Reference model state.
  int   m_starve;
  logic m_last, m_arb;
  logic resp_q[$];
  rq_t  rq[2];

  vec_t tbl[9];
  rq_t  idle, w0, w1;
  obs_t e;

  initial begin
    rst_n = 1'b0;
    idle  = mkrq(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    drive(idle, idle, 32'h0);

    // Directed vectors, applied on consecutive cycles after reset.
    tbl[0].r0 = idle; tbl[0].r1 = idle; tbl[0].rd = 32'h0;
    tbl[0].exp = '0;
    tbl[1].r0 = mkrq(1'b1, 1'b0, 32'h100, 32'h0, 4'hF); tbl[1].r1 = idle; tbl[1].rd = 32'h0;
    tbl[1].exp = grant_obs(tbl[1].r0, 1'b0);
    tbl[2].r0 = idle; tbl[2].r1 = idle; tbl[2].rd = 32'hDEADBEEF;
    tbl[2].exp = '0; tbl[2].exp.m0_rvalid = 1'b1; tbl[2].exp.m0_rdata = 32'hDEADBEEF;
    tbl[3].r0 = idle; tbl[3].r1 = mkrq(1'b1, 1'b1, 32'h200, 32'h12345678, 4'h3); tbl[3].rd = 32'hAAAAAAAA;
    tbl[3].exp = grant_obs(tbl[3].r1, 1'b1);
    tbl[4].r0 = idle; tbl[4].r1 = idle; tbl[4].rd = 32'h55555555;
    tbl[4].exp = '0; tbl[4].exp.owner = 1'b1;
    tbl[5].r0 = mkrq(1'b1, 1'b0, 32'h10, 32'h0, 4'h0); tbl[5].r1 = idle; tbl[5].rd = 32'h0;
    tbl[5].exp = grant_obs(tbl[5].r0, 1'b0);
    tbl[6].r0 = idle; tbl[6].r1 = mkrq(1'b1, 1'b0, 32'h14, 32'h0, 4'h0); tbl[6].rd = 32'h11111111;
    tbl[6].exp = grant_obs(tbl[6].r1, 1'b1);
    tbl[6].exp.m0_rvalid = 1'b1; tbl[6].exp.m0_rdata = 32'h11111111;
    tbl[7].r0 = idle; tbl[7].r1 = idle; tbl[7].rd = 32'h22222222;
    tbl[7].exp = '0; tbl[7].exp.owner = 1'b1;
    tbl[7].exp.m1_rvalid = 1'b1; tbl[7].exp.m1_rdata = 32'h22222222;
    tbl[8].r0 = mkrq(1'b1, 1'b1, 32'h40, 32'hCAFEF00D, 4'hF); tbl[8].r1 = idle; tbl[8].rd = 32'h33333333;
    tbl[8].exp = grant_obs(tbl[8].r0, 1'b0);

    do_reset();
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      drive(tbl[i].r0, tbl[i].r1, tbl[i].rd);
      #1;
      check($sformatf("vec%0d", i), tbl[i].exp);
    end

    // Continuous contention from reset.
    do_reset();
    w0 = mkrq(1'b1, 1'b1, 32'hA0, 32'h1, 4'hF);
    w1 = mkrq(1'b1, 1'b1, 32'hB0, 32'h2, 4'h1);
    for (int k = 1; k <= 10; k++) begin
      logic g;
`ifdef DMEM_ARB_RR_EN
      g = (k % 2 == 0);
`else
      g = (k % (LIMIT + 1) == 0);
`endif
      @(negedge clk);
      drive(w0, w1, 32'h0);
      #1;
      check($sformatf("contend%0d", k), grant_obs(g ? w1 : w0, g));
    end

    // Reset asserted the cycle after a granted read.
    do_reset();
    @(negedge clk);
    drive(mkrq(1'b1, 1'b0, 32'h300, 32'h0, 4'h0), idle, 32'h0);
    #1;
    check("rst_rd_gnt", grant_obs(mkrq(1'b1, 1'b0, 32'h300, 32'h0, 4'h0), 1'b0));
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    drive(mkrq(1'b1, 1'b0, 32'h300, 32'h0, 4'h0), w1, 32'hFFFFFFFF);
    #1;
    check("rst_low_a", '0);
    @(negedge clk);
    #1;
    check("rst_low_b", '0);
    @(negedge clk);
    drive(idle, idle, 32'hFFFFFFFF);
    rst_n = 1'b1;
    #1;
    check("rst_rel0", '0);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      #1;
      check($sformatf("rst_rel%0d", k), '0);
    end

    // Randomized traffic against the reference model.
    do_reset();
    m_starve = 0; m_last = 1'b1; m_arb = 1'b0;
    resp_q.delete();
    rq[0] = idle; rq[1] = idle;
    for (int c = 0; c < 400; c++) begin
      logic          gv, gi;
      logic [DW-1:0] rd;
      for (int m = 0; m < 2; m++) begin
        if (!rq[m].act) begin
          if ($urandom_range(0, 2) != 0)
            rq[m] = mkrq(1'b1, 1'($urandom), $urandom, $urandom, 4'($urandom));
        end else if ($urandom_range(0, 9) == 0) begin
          rq[m].act = 1'b0;
        end
      end
      rd = $urandom;
      gv = rq[0].act | rq[1].act;
`ifdef DMEM_ARB_RR_EN
      gi = (rq[0].act && rq[1].act) ? ~m_last : rq[1].act & ~rq[0].act;
`else
      gi = (rq[1].act && m_starve >= LIMIT) ? 1'b1 : ~rq[0].act;
`endif
      e = '0;
      if (gv) e = grant_obs(rq[gi], gi);
      else    e.owner = m_arb;
      if (resp_q.size() != 0) begin
        if (resp_q.pop_front()) begin
          e.m1_rvalid = 1'b1; e.m1_rdata = rd;
        end else begin
          e.m0_rvalid = 1'b1; e.m0_rdata = rd;
        end
      end
      @(negedge clk);
      drive(rq[0], rq[1], rd);
      #1;
      check($sformatf("rand%0d", c), e);
      if (rq[1].act && !(gv && gi)) m_starve = (m_starve < 15) ? m_starve + 1 : 15;
      else                          m_starve = 0;
      if (gv) begin
        if (!rq[gi].we) resp_q.push_back(gi);
        m_last = gi;
        m_arb  = gi;
        rq[gi].act = 1'b0;
      end
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-master arbiter sharing the single-ported data memory between the CPU load/store unit (m0) and the DMA/debug port (m1).
- Grants one access per cycle and drives the memory-side address, data, write-enable and strobe bus.
- Tracks in-flight reads, then routes the next-cycle read data back to the requester that issued them.
- Sits between the LSU/DMA and the data memory interface.

Parameters:
- ADDR_W, 32, address width of all address ports.
- DATA_W, 32, data width; strobe width is DATA_W/8.
- STARVE_LIMIT, 4, consecutive denied cycles for m1 before m1 is force-granted. Legal range 1..15.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- m0_req  in  1  m0 access request; held until m0_gnt.
- m0_we  in  1  1 = write, 0 = read.
- m0_addr  in  ADDR_W  m0 byte address.
- m0_wdata  in  DATA_W  m0 write data.
- m0_strb  in  DATA_W/8  m0 byte write strobes.
- m0_gnt  out  1  access accepted this cycle.
- m0_rvalid  out  1  read data valid for m0.
- m0_rdata  out  DATA_W  read data for m0.
- m1_req, m1_we, m1_addr, m1_wdata, m1_strb, m1_gnt, m1_rvalid, m1_rdata: same as m0, for m1.
- mem_addr  out  ADDR_W  memory address.
- mem_write_data  out  DATA_W  memory write data.
- mem_write_en  out  1  memory write enable.
- mem_write_strb  out  DATA_W/8  memory byte strobes.
- mem_read_en  out  1  memory read enable.
- mem_read_data  in  DATA_W  synchronous memory read data, valid 1 cycle after mem_read_en.
- arb_owner  out  1  master granted this cycle (0/1); holds last value when idle.

Behaviour:
- Reset (async, rst_n low):
  - rd_pending=0, rd_owner=0, starve_cnt=0, last_owner=1, arb_owner=0.
  - All gnt and rvalid outputs are 0; rdata outputs are 0.
  - mem_write_en=0, mem_read_en=0; mem_addr, mem_write_data and mem_write_strb are 0.
- Grant is combinational in the same cycle as req:
  - At most one gnt per cycle.
  - A write completes at grant; there is no write response.
- Memory bus:
  - Combinational mux of the granted master's fields.
  - mem_write_en = gnt & we; mem_read_en = gnt & ~we.
  - mem_write_strb is forced to 0 on reads.
  - With no grant, all mem_* outputs are 0.
- Read pipeline:
  - On a granted read, register rd_pending=1 and rd_owner=granted index; otherwise rd_pending=0.
  - mK_rvalid = rd_pending & (rd_owner==K).
  - mK_rdata = mem_read_data when mK_rvalid, else 0.
  - Read latency is 1 cycle from gnt to rvalid.
  - Back-to-back reads are accepted every cycle, including alternating owners; the response order equals the grant order.
- Priority, default build (macro undefined):
  - Fixed priority, m0 over m1.
  - starve_cnt increments (saturating at 15) each cycle m1_req=1 and m1 is not granted.
  - starve_cnt clears when m1 is granted or m1_req=0.
  - When starve_cnt >= STARVE_LIMIT and m1_req=1, m1 is granted even if m0_req=1.
- last_owner / arb_owner:
  - Register the granted index on every grant; unchanged when idle.
- Requester rules:
  - A master may drop req before gnt; this has no side effect beyond clearing its starve count.
  - Request fields must be stable while req is high; the arbiter does not check this.
- Simultaneous events:
  - A grant in the same cycle as a previous read's rvalid is normal pipelined operation.
  - If both masters request while the limit is reached, m1 wins.
- Reset mid-operation: any pending read is discarded; no rvalid is produced after reset deasserts.

Optional Feature:
- Macro DMEM_ARB_RR_EN.
- Defined:
  - Round-robin arbitration. When both masters request, grant the master not equal to last_owner.
  - A single requester always wins.
  - starve_cnt logic is removed; the STARVE_LIMIT parameter is ignored.
  - After reset, last_owner=1, so m0 wins the first contention.
- Undefined: fixed priority with starvation guard, as described under Behaviour.

Test Plan:
- m0 read at addr 0x100, mem_read_data=0xDEADBEEF -> m0_gnt=1 and mem_read_en=1 in cycle T; m0_rvalid=1 with m0_rdata=0xDEADBEEF in T+1; m1_rvalid=0.
- m1 write to addr 0x200, wdata 0x12345678, strb 0x3, m0 idle -> m1_gnt=1, mem_write_en=1, mem_write_strb=0x3, mem_addr=0x200 in the same cycle; no rvalid follows.
- Both requesting continuously, default build, STARVE_LIMIT=4 -> m0 granted 4 cycles, m1 granted in the 5th, then m0 granted 4 more; m1 never waits more than 4 cycles.
- Same stimulus with DMEM_ARB_RR_EN -> grants alternate m0, m1, m0, m1 starting with m0.
- Alternating reads m0@0x10, m1@0x14 on consecutive cycles -> m0_rvalid in T+1, m1_rvalid in T+2, each carrying the data presented in that cycle.
- m0 read granted, rst_n asserted the following cycle -> no rvalid during or after reset; all outputs 0 while reset is low.
